cin_lane_sync: RTL and testbench

CIN_LANE_SYNC -- requirements
Module: cin_lane_sync

---
 rtl/cin_lane_sync.sv | 168 ++++++++++++++++
 tb/tb_cin_lane_sync.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cin_lane_sync.sv
// Lane word synchroniser: hunts for a training word in a narrow beat stream,
// locks onto its word boundary, then checks training or delivers payload words.
module cin_lane_sync #(
    parameter int NBITS = 4,
    parameter int NBEATS = 8,
    parameter logic [NBITS*NBEATS-1:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int LOSS_THRESH = 4,
    parameter AUTO_SLIP = "TRUE"
) (
    input  logic                    aclk_i,
    input  logic                    aresetn_i,
    input  logic [NBITS-1:0]        din_i,
    input  logic                    din_valid_i,
    input  logic                    lock_i,
    input  logic                    lock_rst_i,
    input  logic                    run_en_i,
    input  logic                    capture_i,
    output logic                    slip_o,
    output logic [1:0]              state_o,
    output logic                    locked_o,
    output logic                    running_o,
    output logic [NBITS*NBEATS-1:0] dout_o,
    output logic                    dout_valid_o,
    output logic                    biterr_o,
    output logic [15:0]             err_count_o
);

    localparam int W      = NBITS * NBEATS;
    localparam int HW     = W - NBITS;
    localparam int BEAT_W = $clog2(NBEATS);
    localparam int HUNT_W = $clog2(2 * NBEATS);
    localparam int BAD_W  = $clog2(LOSS_THRESH + 1);
    localparam bit SLIP_EN = (AUTO_SLIP == "TRUE");

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        LOCKED  = 2'd2,
        RUNNING = 2'd3
    } state_t;

    state_t              state;
    logic [HW-1:0]       history;
    logic [NBITS-1:0]    old_beat;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [HUNT_W-1:0]   hunt_cnt;
    logic [BAD_W-1:0]    bad_cnt;
    logic [W-1:0]        window;
    logic                in_lock;
    logic                boundary;
    logic                is_train;

    assign window   = {din_i, history};
    assign in_lock  = (state == LOCKED) || (state == RUNNING);
    assign boundary = din_valid_i && in_lock && (beat_cnt == BEAT_W'(NBEATS - 1));
    assign is_train = (window == TRAIN_SEQUENCE);

    assign state_o   = state;
    assign locked_o  = in_lock;
    assign running_o = (state == RUNNING);

    // old_beat is the beat that just fell out of history, i.e. NBEATS beats back.
    // NOTE: history is a datapath register but is still reset, because the
    // repeat-error check compares against it from the very first beat.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            history  <= '0;
            old_beat <= '0;
        end else if (din_valid_i) begin
            history  <= window[W-1:NBITS];
            old_beat <= history[NBITS-1:0];
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            biterr_o <= 1'b0;
        end else begin
            biterr_o <= !in_lock && din_valid_i && (din_i != old_beat);
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            hunt_cnt     <= '0;
            bad_cnt      <= '0;
            err_count_o  <= '0;
            slip_o       <= 1'b0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; later assignments in
            // this block override, which is how a one-cycle strobe is formed.
            slip_o       <= 1'b0;
            dout_valid_o <= 1'b0;
            if (capture_i) begin
                dout_o <= window;
            end

            if (lock_rst_i) begin
                state       <= IDLE;
                beat_cnt    <= '0;
                hunt_cnt    <= '0;
                bad_cnt     <= '0;
                err_count_o <= '0;
            end else begin
                if (din_valid_i && in_lock) begin
                    beat_cnt <= boundary ? '0 : beat_cnt + BEAT_W'(1);
                end
                if (boundary) begin
                    dout_o       <= window;
                    dout_valid_o <= 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        if (lock_i) begin
                            state    <= HUNT;
                            hunt_cnt <= '0;
                        end
                    end
                    HUNT: begin
                        if (din_valid_i) begin
                            if (is_train) begin
                                state    <= LOCKED;
                                beat_cnt <= '0;
                                hunt_cnt <= '0;
                                bad_cnt  <= '0;
                            end else if (SLIP_EN) begin
                                if (hunt_cnt == HUNT_W'(2 * NBEATS - 1)) begin
                                    slip_o   <= 1'b1;
                                    hunt_cnt <= '0;
                                end else begin
                                    hunt_cnt <= hunt_cnt + HUNT_W'(1);
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
                            if (is_train) begin
                                bad_cnt <= '0;
                            end else if (run_en_i) begin
                                state <= RUNNING;
                            end else begin
                                if (err_count_o != 16'hFFFF) begin
                                    err_count_o <= err_count_o + 16'd1;
                                end
                                if (bad_cnt == BAD_W'(LOSS_THRESH - 1)) begin
                                    state    <= HUNT;
                                    bad_cnt  <= '0;
                                    hunt_cnt <= '0;
                                end else begin
                                    bad_cnt <= bad_cnt + BAD_W'(1);
                                end
                            end
                        end
                    end
                    RUNNING: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cin_lane_sync.sv
// Self-checking bench for cin_lane_sync: expected captured words are queued as
// stimulus is driven and compared whenever dout_valid_o strobes.
module tb_cin_lane_sync;

    localparam logic [31:0] TRAIN = 32'hA55A6996;
    localparam logic [31:0] BAD   = 32'h12345678;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  din;
    logic        din_valid;
    logic        lock;
    logic        lock_rst;
    logic        run_en;
    logic        capture;
    logic        slip;
    logic [1:0]  state;
    logic        locked;
    logic        running;
    logic [31:0] dout;
    logic        dout_valid;
    logic        biterr;
    logic [15:0] err_count;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    int          pulses = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    int          last_interval = 0;
    int          biterr_seen = 0;

    cin_lane_sync dut (
        .aclk_i       (aclk),
        .aresetn_i    (aresetn),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .lock_i       (lock),
        .lock_rst_i   (lock_rst),
        .run_en_i     (run_en),
        .capture_i    (capture),
        .slip_o       (slip),
        .state_o      (state),
        .locked_o     (locked),
        .running_o    (running),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .biterr_o     (biterr),
        .err_count_o  (err_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, then sample #1 after the edge; the scoreboard lives here.
    task automatic step(input logic v, input logic [3:0] d);
        logic [31:0] e;
        din_valid = v;
        din       = d;
        @(posedge aclk);
        #1;
        if (biterr === 1'b1) biterr_seen++;
        if (dout_valid === 1'b1) begin
            pulses++;
            last_interval  = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_unexpected: dout_o=%h with no word expected", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    tests_failed++;
                    $display("FAIL scoreboard_word: dout_o=%h expected %h", dout, e);
                end
            end
        end
        if (slip === 1'b1) begin
            tests_run++;
            if (state !== 2'd1) begin
                tests_failed++;
                $display("FAIL slip_outside_hunt: state_o=%0d expected 1", state);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) step(1'b0, 4'hF);
            step(1'b1, w[4*i +: 4]);
        end
    endtask

    task automatic scoreboard_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_words: %0d words never produced, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    function automatic logic [3:0] stream_bits(input int p);
        logic [31:0] t;
        logic [3:0]  b;
        t = TRAIN;
        for (int i = 0; i < 4; i++) b[i] = t[(p + i) % 32];
        return b;
    endfunction

    task automatic do_reset();
        aresetn  = 1'b0;
        din      = '0;
        din_valid = 1'b0;
        lock     = 1'b0;
        lock_rst = 1'b0;
        run_en   = 1'b0;
        capture  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic enter_lock(input int gap);
        lock = 1'b1;
        step(1'b0, 4'h0);
        send_word(TRAIN, gap);
        tests_run++;
        if (state !== 2'd2) begin
            tests_failed++;
            $display("FAIL lock_acquire: state_o=%0d expected 2", state);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        din = '0; din_valid = 1'b0; lock = 1'b0; lock_rst = 1'b0;
        run_en = 1'b0; capture = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        tests_run++;
        if (state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: state_o=%0d expected 0", state);
        end
        tests_run++;
        if ({locked, running, slip, dout_valid, biterr, err_count, dout} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: dout_o=%h err_count_o=%h flags=%b expected all zero",
                     dout, err_count, {locked, running, slip, dout_valid, biterr});
        end
        aresetn = 1'b1;
    endtask

    task automatic test_lock_train();
        int p0;
        do_reset();
        lock = 1'b1;
        step(1'b0, 4'h0);
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL idle_to_hunt: state_o=%0d expected 1", state);
        end
        send_word(TRAIN, 0);
        tests_run++;
        if (state !== 2'd2 || locked !== 1'b1 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_within_word: state_o=%0d locked_o=%b running_o=%b expected 2/1/0",
                     state, locked, running);
        end
        p0 = pulses;
        repeat (2) begin
            exp_q.push_back(TRAIN);
            send_word(TRAIN, 0);
        end
        capture = 1'b1;
        exp_q.push_back(TRAIN);
        send_word(TRAIN, 0);
        capture = 1'b0;
        tests_run++;
        if (pulses - p0 != 3 || last_interval != 8) begin
            tests_failed++;
            $display("FAIL boundary_rate: pulses=%0d interval=%0d expected 3 and 8",
                     pulses - p0, last_interval);
        end
        scoreboard_drained("lock_train");
    endtask

    task automatic test_slow_valid();
        int p0;
        do_reset();
        enter_lock(2);
        p0 = pulses;
        repeat (2) begin
            exp_q.push_back(TRAIN);
            send_word(TRAIN, 2);
        end
        tests_run++;
        if (pulses - p0 != 2 || last_interval != 24) begin
            tests_failed++;
            $display("FAIL slow_valid_rate: pulses=%0d interval=%0d expected 2 and 24",
                     pulses - p0, last_interval);
        end
        scoreboard_drained("slow_valid");
    endtask

    task automatic test_auto_slip();
        int slips = 0;
        int last_slip = 0;
        int p = 1;
        bit got_lock = 1'b0;
        do_reset();
        lock = 1'b1;
        step(1'b0, 4'h0);
        for (int n = 1; n <= 200 && !got_lock; n++) begin
            step(1'b1, stream_bits(p));
            p = (p + 4) % 32;
            if (slip === 1'b1) begin
                slips++;
                tests_run++;
                if (slips == 1 && n != 16) begin
                    tests_failed++;
                    $display("FAIL first_slip: slip at beat %0d expected 16", n);
                end else if (slips > 1 && n - last_slip != 16) begin
                    tests_failed++;
                    $display("FAIL slip_period: %0d beats between slips expected 16", n - last_slip);
                end
                last_slip = n;
                p = (p + 1) % 32;
            end
            if (state === 2'd2) got_lock = 1'b1;
        end
        tests_run++;
        if (!got_lock || slips < 1) begin
            tests_failed++;
            $display("FAIL slip_lock: locked=%0d slips=%0d expected lock after at least 1 slip",
                     got_lock, slips);
        end
        scoreboard_drained("auto_slip");
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        enter_lock(0);
        exp_q.push_back(TRAIN);
        send_word(TRAIN, 0);
        biterr_seen = 0;
        repeat (3) begin
            exp_q.push_back(BAD);
            send_word(BAD, 0);
        end
        tests_run++;
        if (state !== 2'd2 || err_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL three_bad: state_o=%0d err_count_o=%0d expected 2 and 3", state, err_count);
        end
        exp_q.push_back(BAD);
        send_word(BAD, 0);
        tests_run++;
        if (state !== 2'd1 || err_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL loss_of_lock: state_o=%0d err_count_o=%0d expected 1 and 4", state, err_count);
        end
        tests_run++;
        if (biterr_seen != 0) begin
            tests_failed++;
            $display("FAIL biterr_while_locked: %0d pulses expected 0", biterr_seen);
        end
        scoreboard_drained("loss_of_lock");
        lock_rst = 1'b1;
        step(1'b0, 4'h0);
        lock_rst = 1'b0;
        tests_run++;
        if (state !== 2'd0 || err_count !== 16'd0 || dout !== BAD) begin
            tests_failed++;
            $display("FAIL lock_rst: state_o=%0d err_count_o=%0d dout_o=%h expected 0/0/%h",
                     state, err_count, dout, BAD);
        end
        step(1'b0, 4'h0);
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL relock_after_rst: state_o=%0d expected 1", state);
        end
    endtask

    task automatic test_bad_recover();
        do_reset();
        enter_lock(0);
        repeat (3) begin
            exp_q.push_back(BAD);
            send_word(BAD, 0);
        end
        exp_q.push_back(TRAIN);
        send_word(TRAIN, 0);
        tests_run++;
        if (state !== 2'd2 || err_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL train_clears: state_o=%0d err_count_o=%0d expected 2 and 3", state, err_count);
        end
        repeat (3) begin
            exp_q.push_back(BAD);
            send_word(BAD, 0);
        end
        tests_run++;
        if (state !== 2'd2 || err_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL bad_restart: state_o=%0d err_count_o=%0d expected 2 and 6", state, err_count);
        end
        exp_q.push_back(BAD);
        send_word(BAD, 0);
        tests_run++;
        if (state !== 2'd1 || err_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL bad_threshold: state_o=%0d err_count_o=%0d expected 1 and 7", state, err_count);
        end
        scoreboard_drained("bad_recover");
    endtask

    task automatic test_running();
        int p0;
        do_reset();
        enter_lock(0);
        run_en = 1'b1;
        p0 = pulses;
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 0);
        tests_run++;
        if (state !== 2'd3 || running !== 1'b1 || locked !== 1'b1 || dout !== 32'hDEADBEEF
            || pulses - p0 != 1) begin
            tests_failed++;
            $display("FAIL enter_running: state_o=%0d run=%b lock=%b dout_o=%h pulses=%0d expected 3/1/1/deadbeef/1",
                     state, running, locked, dout, pulses - p0);
        end
        run_en = 1'b0;
        exp_q.push_back(BAD);
        send_word(BAD, 0);
        exp_q.push_back(TRAIN);
        send_word(TRAIN, 0);
        tests_run++;
        if (state !== 2'd3 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL running_no_checks: state_o=%0d err_count_o=%0d expected 3 and 0", state, err_count);
        end
        scoreboard_drained("running");
        #3;
        aresetn = 1'b0;
        #1;
        tests_run++;
        if ({state, locked, running, slip, dout_valid, biterr, err_count, dout} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: state_o=%0d dout_o=%h err_count_o=%h expected all zero",
                     state, dout, err_count);
        end
        do_reset();
    endtask

    task automatic test_capture();
        logic [31:0] x;
        logic [31:0] e;
        do_reset();
        x = 32'h0FEDCBA9;
        send_word(x, 0);
        capture = 1'b1;
        step(1'b0, 4'hC);
        e = {4'hC, x[31:4]};
        tests_run++;
        if (dout !== e || dout_valid !== 1'b0 || state !== 2'd0) begin
            tests_failed++;
            $display("FAIL capture_idle: dout_o=%h valid=%b state_o=%0d expected %h/0/0",
                     dout, dout_valid, state, e);
        end
        step(1'b0, 4'h3);
        capture = 1'b0;
        e = {4'h3, x[31:4]};
        tests_run++;
        if (dout !== e) begin
            tests_failed++;
            $display("FAIL capture_frozen_history: dout_o=%h expected %h", dout, e);
        end
    endtask

    task automatic test_biterr();
        logic [31:0] x;
        do_reset();
        x = 32'h13572468;
        send_word(x, 0);
        biterr_seen = 0;
        send_word(x, 0);
        tests_run++;
        if (biterr_seen != 0) begin
            tests_failed++;
            $display("FAIL biterr_repeat: %0d pulses expected 0", biterr_seen);
        end
        biterr_seen = 0;
        send_word(x ^ 32'h00000F00, 0);
        tests_run++;
        if (biterr_seen != 1) begin
            tests_failed++;
            $display("FAIL biterr_single: %0d pulses expected 1", biterr_seen);
        end
    endtask

    initial begin
        test_reset();
        test_lock_train();
        test_slow_valid();
        test_auto_slip();
        test_loss_of_lock();
        test_bad_recover();
        test_running();
        test_capture();
        test_biterr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
